// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the access legality check.
`timescale 1ns/1ps
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  // True when the width code is illegal for the access kind or the address is misaligned.
  function automatic logic access_fault(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic legal;
    logic misaligned;
    case (f3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !is_store;
      default:          legal = 1'b0;
    endcase
    misaligned = ((f3 == F3_H || f3 == F3_HU) && off[0]) || (f3 == F3_W && off != 2'b00);
    return !legal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: load extraction/extension and store merging
// for little-endian sub-word accesses.
`timescale 1ns/1ps
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] load_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = load_word[7:0];
      2'd1:    byte_sel = load_word[15:8];
      2'd2:    byte_sel = load_word[23:16];
      default: byte_sel = load_word[31:24];
    endcase
    half_sel = offset[1] ? load_word[31:16] : load_word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'b0, byte_sel};
      F3_HU:   load_data = {16'b0, half_sel};
      default: load_data = load_word;
    endcase
  end

  // Word stores ignore old_word, so a stale merge register is harmless for SW.
  always_comb begin
    store_word = old_word;
    case (funct3)
      F3_B: begin
        case (offset)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (offset[1]) store_word[31:16] = wdata[15:0];
        else           store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Sub-word load/store engine between execute and a word-only data memory;
// byte/half stores are done as read-modify-write.
`timescale 1ns/1ps
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_MemRead,
  output logic        mem_MemWrite,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [2:0]  funct3_q;
  logic        is_store_q;
  logic        fault_q;
  logic        req_fault;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign req_fault = access_fault(is_store, funct3, addr[1:0]);

  lsu_align u_align (
    .load_word  (mem_read_data),
    .old_word   (merge_q),
    .wdata      (wdata_q),
    .offset     (addr_q[1:0]),
    .funct3     (funct3_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      fault_q    <= 1'b0;
      rdata      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            addr_q     <= addr;
            wdata_q    <= wdata;
            funct3_q   <= funct3;
            is_store_q <= is_store;
            fault_q    <= req_fault;
            if (req_fault) begin
              rdata <= '0;
              state <= ST_RESP;
            end else if (is_store && funct3 == F3_W) begin
              state <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (is_store_q) begin
            merge_q <= mem_read_data;
            state   <= ST_WR;
          end else begin
            rdata <= load_data;
            state <= ST_RESP;
          end
        end
        ST_WR: begin
          rdata <= '0;
          state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory controls come from registered state only; rst gates the write so a
  // reset landing in WR never commits.
  assign busy           = (state != ST_IDLE);
  assign done           = (state == ST_RESP);
  assign fault          = done & fault_q;
  assign mem_MemRead    = (state == ST_RD);
  assign mem_MemWrite   = (state == ST_WR) & !rst;
  assign mem_addr       = (state == ST_RD || state == ST_WR) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_write_data = (state == ST_WR) ? store_word : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory attached
// to the memory port.
`timescale 1ns/1ps
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        preload;
  logic [31:0] mem [0:63];

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .is_store       (is_store),
    .funct3         (funct3),
    .addr           (addr),
    .wdata          (wdata),
    .busy           (busy),
    .done           (done),
    .fault          (fault),
    .rdata          (rdata),
    .mem_addr       (mem_addr),
    .mem_MemRead    (mem_MemRead),
    .mem_MemWrite   (mem_MemWrite),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  assign mem_read_data = mem_MemRead ? mem[mem_addr[7:2]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8899_AABB;
      mem[8] <= 32'h55AA_55AA;
    end else if (mem_MemWrite) begin
      mem[mem_addr[7:2]] <= mem_write_data;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "/busy"},     {31'b0, busy}, 32'h0);
    check_output({tag, "/done"},     {31'b0, done}, 32'h0);
    check_output({tag, "/fault"},    {31'b0, fault}, 32'h0);
    check_output({tag, "/rdata"},    rdata, 32'h0);
    check_output({tag, "/mem_addr"}, mem_addr, 32'h0);
    check_output({tag, "/rd_en"},    {31'b0, mem_MemRead}, 32'h0);
    check_output({tag, "/wr_en"},    {31'b0, mem_MemWrite}, 32'h0);
    check_output({tag, "/wr_data"},  mem_write_data, 32'h0);
  endtask

  // Waits for done, counting cycles and memory enables, then pops and compares.
  task automatic wait_done(input string tag, input int exp_rd, input int exp_wr);
    int   n = 0;
    int   rd_n = 0;
    int   wr_n = 0;
    bit   seen = 1'b0;
    exp_t e;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_MemRead) rd_n++;
      if (mem_MemWrite) wr_n++;
      if (mem_MemRead || mem_MemWrite)
        check_output({tag, "/mem_addr"}, mem_addr, {addr[31:2], 2'b00});
      check_output({tag, "/busy"}, {31'b0, busy}, 32'h1);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check_output({tag, "/timeout"}, 32'h0, 32'h1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      check_output({tag, "/unexpected_done"}, 32'h1, 32'h0);
      return;
    end
    e = sb_q.pop_front();
    check_output({tag, "/rdata"}, rdata, e.rdata);
    check_output({tag, "/fault"}, {31'b0, fault}, {31'b0, e.fault});
    if (e.lat > 0) check_output({tag, "/latency"}, n, e.lat);
    if (exp_rd >= 0) begin
      check_output({tag, "/rd_cycles"}, rd_n, exp_rd);
      check_output({tag, "/wr_cycles"}, wr_n, exp_wr);
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] exp_rdata, input logic exp_fault,
                                input int exp_lat);
    exp_t e;
    int   erd;
    int   ewr;
    @(negedge clk);
    req      = 1'b1;
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    e.rdata  = exp_rdata;
    e.fault  = exp_fault;
    e.lat    = exp_lat;
    sb_q.push_back(e);
    erd = (!exp_fault && (!st || f3 != F3_W)) ? 1 : 0;
    ewr = (!exp_fault && st) ? 1 : 0;
    wait_done(tag, erd, ewr);
    req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    rst      = 1'b1;
    preload  = 1'b1;
    req      = 1'b0;
    is_store = 1'b0;
    funct3   = 3'b000;
    addr     = 32'h0;
    wdata    = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst     = 1'b0;
    preload = 1'b0;

    apply_stimulus("lb",  1'b0, F3_B,  32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0, 2);
    apply_stimulus("lbu", 1'b0, F3_BU, 32'h11, 32'h0, 32'h0000_00AA, 1'b0, 2);
    apply_stimulus("lh",  1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF_8899, 1'b0, 2);
    apply_stimulus("lhu", 1'b0, F3_HU, 32'h12, 32'h0, 32'h0000_8899, 1'b0, 2);
    apply_stimulus("lw",  1'b0, F3_W,  32'h10, 32'h0, 32'h8899_AABB, 1'b0, 2);

    apply_stimulus("sb",  1'b1, F3_B,  32'h13, 32'h1234_5677, 32'h0, 1'b0, 3);
    check_output("sb/mem", mem[4], 32'h7799_AABB);
    apply_stimulus("sh",  1'b1, F3_H,  32'h12, 32'h0000_CAFE, 32'h0, 1'b0, 3);
    check_output("sh/mem", mem[4], 32'hCAFE_AABB);

    apply_stimulus("sh_misaligned", 1'b1, F3_H, 32'h11, 32'h0000_1234, 32'h0, 1'b1, 1);
    check_output("sh_misaligned/mem", mem[4], 32'hCAFE_AABB);
    apply_stimulus("ld_f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    apply_stimulus("lw_after", 1'b0, F3_W, 32'h10, 32'h0, 32'hCAFE_AABB, 1'b0, 2);

    // SW interrupted by reset while in WR.
    @(negedge clk);
    req      = 1'b1;
    is_store = 1'b1;
    funct3   = F3_W;
    addr     = 32'h20;
    wdata    = 32'hDEAD_BEEF;
    @(negedge clk);
    check_output("rst_wr/wr_en_before", {31'b0, mem_MemWrite}, 32'h1);
    rst = 1'b1;
    #1;
    check_output("rst_wr/wr_en_gated", {31'b0, mem_MemWrite}, 32'h0);
    @(negedge clk);
    check_reset_outputs("rst_wr");
    check_output("rst_wr/mem", mem[8], 32'h55AA_55AA);
    rst = 1'b0;
    req = 1'b0;

    // Held request: each IDLE entry accepts exactly one access.
    e.rdata = 32'hCAFE_AABB;
    e.fault = 1'b0;
    e.lat   = 0;
    repeat (3) sb_q.push_back(e);
    @(negedge clk);
    req      = 1'b1;
    is_store = 1'b0;
    funct3   = F3_W;
    addr     = 32'h10;
    for (int i = 0; i < 3; i++) begin
      wait_done("held", -1, -1);
      @(negedge clk);
      check_output("held/gap_busy", {31'b0, busy}, 32'h0);
      check_output("held/done_pulse", {31'b0, done}, 32'h0);
      if (i < 2) begin
        @(negedge clk);
        check_output("held/reaccept", {31'b0, busy}, 32'h1);
      end else begin
        req = 1'b0;
      end
    end
    @(negedge clk);
    check_output("held/stopped", {31'b0, busy}, 32'h0);
    check_output("held/queue_empty", sb_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
